// File: rtl/wb_master_bridge_if.sv
// Command/response stream plus Wishbone classic bus bundle for wb_master_bridge.
// master: the bridge's view. slave: the requester/responder environment's view.
interface wb_master_bridge_if #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4
);
  // command stream
  logic                     cmd_valid_i;
  logic                     cmd_ready_o;
  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i;
  logic [WB_DATA_WIDTH-1:0] cmd_data_i;
  logic                     cmd_we_i;
  logic [WB_SEL_WIDTH-1:0]  cmd_sel_i;
  // response stream
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [WB_DATA_WIDTH-1:0] rsp_data_o;
  logic                     rsp_err_o;
  // wishbone bus
  logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
  logic [WB_DATA_WIDTH-1:0] wb_data_o;
  logic                     wb_we_o;
  logic [WB_SEL_WIDTH-1:0]  wb_sel_o;
  logic                     wb_cyc_o;
  logic                     wb_stb_o;
  logic [WB_DATA_WIDTH-1:0] wb_data_i;
  logic                     wb_ack_i;
  // status
  logic                     busy_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_we_i, cmd_sel_i,
    input  rsp_ready_i, wb_data_i, wb_ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    output busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_we_i, cmd_sel_i,
    output rsp_ready_i, wb_data_i, wb_ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    input  busy_o
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle,
// one response out (read data or timeout error). All outputs are registered.
module wb_master_bridge #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  wb_master_bridge_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  // Timeout fires on the edge where the counter reaches TIMEOUT_CYCLES-1,
  // which leaves cyc high for exactly TIMEOUT_CYCLES cycles.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_e                   state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [WB_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                     busy_q, busy_d;

  // State and output registers; reset drops cyc asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a case changes it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    unique case (state_q)
      IDLE: begin
        // ready comes up on the first edge after reset release
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid_i && cmd_ready_q) begin
          addr_d      = bus.cmd_addr_i;
          wdata_d     = bus.cmd_data_i;
          we_d        = bus.cmd_we_i;
          sel_d       = bus.cmd_sel_i;
          cyc_d       = 1'b1;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          state_d     = BUS;
        end
      end
      BUS: begin
        if (bus.wb_ack_i) begin
          // ack beats a coincident timeout
          cyc_d       = 1'b0;
          rsp_data_d  = we_q ? '0 : bus.wb_data_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          cyc_d       = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_data_o   = wdata_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.busy_o      = busy_q;

endmodule
